// File: rtl/dvi_video_timing.sv
// DVI raster timing: counters drive a combinational pixel-fetch request, sync/DE/RGB follow one cycle later.
// Latency: 1 cycle from request to encoder outputs; no backpressure, the pixel source must answer every cycle.
module dvi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    output logic [10:0] req_x,
    output logic [10:0] req_y,
    input  logic [23:0] pix_data,
    output logic        DE,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        hs_on;
    logic        vs_on;

    assign req_valid = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign req_x     = h_cnt;
    assign req_y     = v_cnt;

    assign hs_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            DE          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
            DE          <= req_valid;
            hsync       <= hs_on ? HS_POL : ~HS_POL;
            vsync       <= vs_on ? VS_POL : ~VS_POL;
            line_start  <= (h_cnt == 11'd0);
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    // The source's registered answer arrives in the same cycle as the registered DE,
    // so gating here keeps RGB aligned with sync and ignores pix_data outside DE.
    assign {red, green, blue} = DE ? pix_data : 24'h0;
endmodule
